// File: rtl/VX_fpu_pkg.sv
// Shared types and sizing helpers for the FPU commit packer.
package VX_fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FULL  = 2'd2
  } packer_state_t;

  function automatic int calc_num_pkts(input int threads, input int lanes);
    return threads / lanes;
  endfunction

  // A single-slice warp needs no pid bits at all.
  function automatic int calc_pid_bits(input int pkts);
    return (pkts > 1) ? $clog2(pkts) : 0;
  endfunction

endpackage

// File: rtl/vx_fpu_commit_packer.sv
// Packs NUM_LANES-wide FPU commit slices into one NUM_THREADS-wide warp commit.
// Optional FPU_PACKER_PERF_EN adds perf_commits / perf_stalls counters.
module vx_fpu_commit_packer
  import VX_fpu_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int XLEN        = 32,
  parameter int UUID_WIDTH  = 44,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6,
  localparam int NUM_PKTS   = calc_num_pkts(NUM_THREADS, NUM_LANES),
  localparam int PID_BITS   = calc_pid_bits(NUM_PKTS),
  localparam int PID_WIDTH  = (PID_BITS > 0) ? PID_BITS : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [XLEN-1:0]             in_PC,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [XLEN-1:0]             out_PC,
  output logic [NR_BITS-1:0]          out_rd,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data
`ifdef FPU_PACKER_PERF_EN
  ,
  output logic [63:0]                 perf_commits,
  output logic [63:0]                 perf_stalls
`endif
);

  packer_state_t         r_state;
  logic [UUID_WIDTH-1:0] r_uuid;
  logic [NW_WIDTH-1:0]   r_wid;
  logic [XLEN-1:0]       r_PC;
  logic [NR_BITS-1:0]    r_rd;

  logic w_in_fire;
  logic w_out_fire;
  logic w_sop;
  logic w_last;

  // Reset masks the handshakes so nothing fires on the reset cycle.
  assign in_ready   = !reset && ((r_state != FULL) || out_ready);
  assign out_valid  = !reset && (r_state == FULL);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Outside ACCUM every accepted slice opens a new instruction, whether or not it carries sop.
  assign w_sop  = in_sop || (r_state != ACCUM);
  assign w_last = in_eop || (NUM_PKTS == 1);

  // Per-slot write / clear decode and slice storage.
  for (genvar p = 0; p < NUM_PKTS; p++) begin : g_slot
    logic                      w_hit;
    logic                      w_we;
    logic                      w_clr;
    logic [NUM_LANES-1:0]      r_tmask;
    logic [NUM_LANES*XLEN-1:0] r_data;

    if (NUM_PKTS == 1) begin : g_single
      assign w_hit = 1'b1;
    end else begin : g_multi
      assign w_hit = (in_pid == PID_WIDTH'(p));
    end

    assign w_we  = w_in_fire && w_hit;
    assign w_clr = w_in_fire && w_sop && !w_hit;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_tmask <= '0;
      end else if (w_we) begin
        r_tmask <= in_tmask;
      end else if (w_clr) begin
        r_tmask <= '0;
      end
    end

    always_ff @(posedge clk) begin
      if (w_we) begin
        r_data <= in_data;
      end else if (w_clr) begin
        r_data <= '0;
      end
    end

    assign out_tmask[p*NUM_LANES +: NUM_LANES]           = r_tmask;
    assign out_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = r_data;
  end

  always_ff @(posedge clk) begin
    if (w_in_fire && w_sop) begin
      r_uuid <= in_uuid;
      r_wid  <= in_wid;
      r_PC   <= in_PC;
      r_rd   <= in_rd;
    end
  end

  assign out_uuid = r_uuid;
  assign out_wid  = r_wid;
  assign out_PC   = r_PC;
  assign out_rd   = r_rd;

  // An incoming slice takes priority: when it coincides with a drain it decides the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (w_in_fire) begin
      r_state <= w_last ? FULL : ACCUM;
    end else if (w_out_fire) begin
      r_state <= IDLE;
    end
  end

`ifdef FPU_PACKER_PERF_EN
  logic [63:0] r_perf_commits;
  logic [63:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_commits <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (w_out_fire) begin
        r_perf_commits <= r_perf_commits + 64'd1;
      end
      if ((r_state == FULL) && !out_ready) begin
        r_perf_stalls <= r_perf_stalls + 64'd1;
      end
    end
  end

  assign perf_commits = r_perf_commits;
  assign perf_stalls  = r_perf_stalls;
`endif

`ifndef SYNTHESIS
  // Upstream protocol violations are reported but recovered from in hardware.
  a_sop_in_accum: assert property (@(posedge clk) disable iff (reset)
    !(w_in_fire && in_sop && (r_state == ACCUM)))
    else $warning("packer: sop while accumulating, partial warp discarded");

  a_nosop_in_idle: assert property (@(posedge clk) disable iff (reset)
    !(w_in_fire && !in_sop && (r_state == IDLE)))
    else $warning("packer: slice without sop while idle, treated as sop");

  a_meta_change: assert property (@(posedge clk) disable iff (reset)
    !(w_in_fire && !in_sop && (r_state == ACCUM) && ((in_wid != r_wid) || (in_uuid != r_uuid))))
    else $warning("packer: wid/uuid changed within one warp");
`endif

endmodule

// File: tb/tb_vx_fpu_commit_packer.sv
// Randomized bench for vx_fpu_commit_packer with a lane-array reference model.
module tb_vx_fpu_commit_packer;

  localparam int NT  = 8;
  localparam int NL  = 4;
  localparam int XL  = 32;
  localparam int UW  = 44;
  localparam int NWW = 2;
  localparam int NRB = 6;
  localparam int CW  = NT * XL;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [UW-1:0]     in_uuid = '0;
  logic [NWW-1:0]    in_wid = '0;
  logic [XL-1:0]     in_PC = '0;
  logic [NRB-1:0]    in_rd = '0;
  logic [NL-1:0]     in_tmask = '0;
  logic [NL*XL-1:0]  in_data = '0;
  logic [0:0]        in_pid = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [UW-1:0]     out_uuid;
  logic [NWW-1:0]    out_wid;
  logic [XL-1:0]     out_PC;
  logic [NRB-1:0]    out_rd;
  logic [NT-1:0]     out_tmask;
  logic [CW-1:0]     out_data;
`ifdef FPU_PACKER_PERF_EN
  logic [63:0]       perf_commits;
  logic [63:0]       perf_stalls;
`endif

  vx_fpu_commit_packer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_wid(in_wid), .in_PC(in_PC), .in_rd(in_rd),
    .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_uuid(out_uuid), .out_wid(out_wid), .out_PC(out_PC), .out_rd(out_rd),
    .out_tmask(out_tmask), .out_data(out_data)
`ifdef FPU_PACKER_PERF_EN
    , .perf_commits(perf_commits), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: lane arrays for the warp being built plus one pending commit.
  logic [XL-1:0]  a_data [NT];
  bit             a_mask [NT];
  logic [UW-1:0]  a_uuid;
  logic [NWW-1:0] a_wid;
  logic [XL-1:0]  a_PC;
  logic [NRB-1:0] a_rd;
  bit             m_acc = 0;
  bit             m_full = 0;
  logic [UW-1:0]  p_uuid;
  logic [NWW-1:0] p_wid;
  logic [XL-1:0]  p_PC;
  logic [NRB-1:0] p_rd;
  logic [NT-1:0]  p_mask;
  logic [CW-1:0]  p_data;
  longint unsigned m_commits = 0;
  longint unsigned m_stalls  = 0;
  bit             fire_seen = 0;
  int             dut_fires = 0;

  always @(negedge clk) begin
    bit exp_rdy, ofire, ifire, sop;
    int base;
    if (reset) begin
      check("rst_out_valid", CW'(out_valid), '0);
      check("rst_in_ready", CW'(in_ready), '0);
      m_full = 0; m_acc = 0; m_commits = 0; m_stalls = 0; fire_seen = 0;
    end else begin
`ifdef FPU_PACKER_PERF_EN
      check("perf_commits", CW'(perf_commits), CW'(m_commits));
      check("perf_stalls", CW'(perf_stalls), CW'(m_stalls));
`endif
      exp_rdy = !m_full || out_ready;
      check("in_ready", CW'(in_ready), CW'(exp_rdy));
      check("out_valid", CW'(out_valid), CW'(m_full));
      if (m_full) begin
        check("out_uuid", CW'(out_uuid), CW'(p_uuid));
        check("out_wid", CW'(out_wid), CW'(p_wid));
        check("out_PC", CW'(out_PC), CW'(p_PC));
        check("out_rd", CW'(out_rd), CW'(p_rd));
        check("out_tmask", CW'(out_tmask), CW'(p_mask));
        check("out_data", out_data, p_data);
      end
      if (out_valid && out_ready) dut_fires++;
      ofire = m_full && out_ready;
      ifire = in_valid && exp_rdy;
      if (m_full && !out_ready) m_stalls++;
      if (ofire) begin
        m_full = 0;
        m_commits++;
      end
      if (ifire) begin
        sop = in_sop || !m_acc;
        if (sop) begin
          for (int i = 0; i < NT; i++) begin
            a_mask[i] = 0;
            a_data[i] = '0;
          end
          a_uuid = in_uuid; a_wid = in_wid; a_PC = in_PC; a_rd = in_rd;
        end
        base = int'(in_pid) * NL;
        for (int l = 0; l < NL; l++) begin
          a_mask[base + l] = in_tmask[l];
          a_data[base + l] = in_data[l*XL +: XL];
        end
        if (in_eop) begin
          for (int i = 0; i < NT; i++) begin
            p_mask[i] = a_mask[i];
            p_data[i*XL +: XL] = a_data[i];
          end
          p_uuid = a_uuid; p_wid = a_wid; p_PC = a_PC; p_rd = a_rd;
          m_full = 1;
          m_acc  = 0;
        end else begin
          m_acc = 1;
        end
      end
      fire_seen = ifire;
    end
  end

  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom);
    end
  endtask

  task automatic send(input logic [UW-1:0] u, input logic [NWW-1:0] w, input logic [XL-1:0] pc,
                      input logic [NRB-1:0] rd, input logic [NL-1:0] tm, input logic [NL*XL-1:0] d,
                      input bit pid, input bit sop, input bit eop, input bit rnd, output int cyc);
    bit acc;
    in_uuid = u; in_wid = w; in_PC = pc; in_rd = rd; in_tmask = tm; in_data = d;
    in_pid = pid; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    cyc = 0;
    acc = 0;
    while (!acc && cyc < 200) begin
      @(posedge clk);
      cyc++;
      acc = fire_seen;
      #1;
      if (rnd) out_ready = 1'($urandom);
    end
    if (!acc) check("send_timeout", '0, CW'(1));
    in_valid = 1'b0;
  endtask

  int n_expect = 0;

  initial begin
    int cyc;
    logic [UW-1:0] u;
    idle(3, 0);
    reset = 1'b0;
    #1;
    check("rst_tmask", CW'(out_tmask), '0);

    // Two-slice pack followed by a 5-cycle stall.
    out_ready = 1'b0;
    send(44'h123, 2'd1, 32'h1000, 6'd3, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 1'b1, 1'b0, 0, cyc);
    send(44'h123, 2'd1, 32'h1000, 6'd3, 4'h3, {32'd8, 32'd7, 32'd6, 32'd5}, 1'b1, 1'b0, 1'b1, 0, cyc);
    idle(5, 0);
    check("t1_tmask", CW'(out_tmask), CW'(8'h3F));
    for (int i = 0; i < 6; i++) check("t1_lane", CW'(out_data[i*XL +: XL]), CW'(i + 1));
    check("t2_in_ready", CW'(in_ready), '0);
`ifdef FPU_PACKER_PERF_EN
    check("t2_stalls", CW'(perf_stalls), CW'(5));
`endif
    out_ready = 1'b1;
    n_expect++;
    idle(1, 0);

    // Drain and accept in the same cycle.
    out_ready = 1'b0;
    send(44'hA, 2'd0, 32'h2000, 6'd1, 4'h1, {4{32'hAAAA}}, 1'b0, 1'b1, 1'b1, 0, cyc);
    out_ready = 1'b1;
    send(44'hB, 2'd2, 32'h2004, 6'd2, 4'h2, {4{32'hBBBB}}, 1'b0, 1'b1, 1'b1, 0, cyc);
    check("t3_no_bubble", CW'(cyc), CW'(1));
    check("t3_out_uuid", CW'(out_uuid), CW'(44'hB));
    n_expect += 2;
    idle(2, 0);

    // Out-of-order pids: metadata comes from the sop slice.
    out_ready = 1'b0;
    send(44'hC, 2'd3, 32'h3000, 6'd7, 4'h9, {4{32'hC1}}, 1'b1, 1'b1, 1'b0, 0, cyc);
    send(44'hC, 2'd3, 32'h3FFF, 6'd9, 4'h6, {4{32'hC0}}, 1'b0, 1'b0, 1'b1, 0, cyc);
    idle(1, 0);
    check("t4_tmask", CW'(out_tmask), CW'(8'h96));
    check("t4_pc", CW'(out_PC), CW'(32'h3000));
    out_ready = 1'b1;
    n_expect++;
    idle(2, 0);

    // Reset in the middle of accumulation.
    send(44'hD, 2'd1, 32'h4000, 6'd4, 4'hF, {4{32'hDD}}, 1'b0, 1'b1, 1'b0, 0, cyc);
    reset = 1'b1;
    idle(1, 0);
    reset = 1'b0;
    idle(1, 0);
    check("t5_out_valid", CW'(out_valid), '0);
    out_ready = 1'b0;
    send(44'hE, 2'd2, 32'h5000, 6'd5, 4'h5, {4{32'hE0}}, 1'b0, 1'b1, 1'b0, 0, cyc);
    send(44'hE, 2'd2, 32'h5000, 6'd5, 4'hA, {4{32'hE1}}, 1'b1, 1'b0, 1'b1, 0, cyc);
    check("t5_tmask", CW'(out_tmask), CW'(8'hA5));
    out_ready = 1'b1;
    n_expect++;
    idle(1, 0);

    // A second sop while accumulating restarts the warp.
    out_ready = 1'b0;
    send(44'hF1, 2'd1, 32'h6000, 6'd6, 4'hF, {4{32'hF1}}, 1'b0, 1'b1, 1'b0, 0, cyc);
    send(44'hF2, 2'd2, 32'h7000, 6'd8, 4'h3, {4{32'hF2}}, 1'b0, 1'b1, 1'b0, 0, cyc);
    send(44'hF2, 2'd2, 32'h7000, 6'd8, 4'hC, {4{32'hF3}}, 1'b1, 1'b0, 1'b1, 0, cyc);
    check("t6_wid", CW'(out_wid), CW'(2));
    check("t6_tmask", CW'(out_tmask), CW'(8'hC3));
    out_ready = 1'b1;
    n_expect++;
    idle(1, 0);

    // Random traffic with random backpressure.
    for (int k = 0; k < 250; k++) begin
      bit first, single;
      logic [NWW-1:0] w;
      logic [XL-1:0]  pc;
      logic [NRB-1:0] rd;
      u = {12'($urandom), 32'($urandom)};
      w = NWW'($urandom);
      pc = 32'($urandom);
      rd = NRB'($urandom);
      first = 1'($urandom);
      single = ($urandom_range(0, 4) == 0);
      if (single) begin
        send(u, w, pc, rd, NL'($urandom), {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
             first, 1'b1, 1'b1, 1, cyc);
      end else begin
        send(u, w, pc, rd, NL'($urandom), {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
             first, 1'b1, 1'b0, 1, cyc);
        if ($urandom_range(0, 2) == 0) idle(1, 1);
        send(u, w, pc, rd, NL'($urandom), {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
             !first, 1'b0, 1'b1, 1, cyc);
      end
      n_expect++;
      idle($urandom_range(0, 2), 1);
    end

    out_ready = 1'b1;
    idle(4, 0);
    check("drained", CW'(out_valid), '0);
    check("commit_count", CW'(dut_fires), CW'(n_expect));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
